fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the single-cycle RISC-V core, directly upstream of the instruction memory. Holds the program counter, drives the word address into instruction memory, forwards the returned word to the decoder, and selects the next PC: sequential, stalled, or redirected. Stops the core on `EBREAK`, on running off the end of the program, or on an illegal redirect target.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `MEM_DEPTH`, default `128`: instruction memory depth in 32-bit words. Valid byte range is `0 .. MEM_DEPTH*4-4`.
- `CNT_WIDTH`, default `32`: width of the performance counters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold the current PC this cycle.
- `branch_taken`  in  1  redirect the PC to `branch_target`.
- `branch_target`  in  32  byte address of the redirect.
- `instruction`  in  32  word returned by instruction memory for `address`.
- `address`  out  32  current PC, to instruction memory.
- `pc_plus4`  out  32  `address + 4`, modulo 2^32 (link value for JAL/JALR).
- `instr_out`  out  32  instruction to the decoder.
- `instr_valid`  out  1  `instr_out` is a real fetched instruction.
- `halted`  out  1  core stopped normally.
- `trap`  out  1  core stopped on an illegal redirect.
- `trap_pc`  out  32  offending `branch_target`.
- `retired_count`  out  CNT_WIDTH  present only with `FETCH_PERF_CNT_EN`.
- `cycle_count`  out  CNT_WIDTH  present only with `FETCH_PERF_CNT_EN`.

## Operation
- States: BOOT, RUN, HALT, TRAP.
- Reset values:
  - `pc = RESET_PC`, state BOOT.
  - `instr_valid = 0`, `instr_out = 32'h0000_0013`.
  - `halted = 0`, `trap = 0`, `trap_pc = 0`.
  - Counters 0.
- BOOT: lasts exactly one cycle. PC is held, output is NOP and invalid, next state is RUN.
- RUN: `instr_out = instruction`, `instr_valid = 1`. Next-PC priority, highest first:
  1. `stall`: PC held, state stays RUN.
  2. `instruction == 32'h0010_0073` (EBREAK): PC held, go to HALT.
  3. `branch_taken` with `branch_target[1:0] != 0`, or `branch_target >= MEM_DEPTH*4`: PC held, `trap_pc <= branch_target`, go to TRAP.
  4. `branch_taken` with a legal target: `pc <= branch_target`.
  5. Otherwise, if `pc + 4 >= MEM_DEPTH*4`: PC held, go to HALT (ran off the end). Else `pc <= pc + 4`.
- HALT and TRAP are sticky until `rst`. In both:
  - `instr_out = 32'h0000_0013`, `instr_valid = 0`.
  - All inputs are ignored and PC is frozen.
  - `halted = 1` in HALT only; `trap = 1` in TRAP only.
- `rst` asserted in any state, including mid-stall or in HALT/TRAP, restores every reset value at the next edge.

## Timing
- PC, state, `trap_pc`, `halted`, `trap` and the counters are registered and update on the rising edge.
- `address = pc`. `pc_plus4`, `instr_out` and `instr_valid` are combinational from the registered state and `instruction`.
- Redirect latency: a branch taken at edge N shows the target on `address` after edge N.
- The first valid instruction appears one cycle after `rst` deasserts.
- `halted` and `trap` rise one edge after the terminating condition is sampled.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `retired_count` increments on every RUN edge without `stall`, including the EBREAK edge and excluding a trapping edge.
  - `cycle_count` increments on every edge in BOOT or RUN, including stalled cycles, and freezes in HALT/TRAP.
  - Both wrap modulo 2^CNT_WIDTH.
- `FETCH_PERF_CNT_EN` undefined: both ports and their logic are absent; all other behaviour is identical.

## Test plan
- Reset then run with no stalls, memory returning `32'h0040_0093` at every address: `address` sequence is 0, 0 (BOOT), 4, 8, 0xC; `instr_valid` goes 0 then 1.
- `stall` held for 3 cycles at PC `0x8`: `address` stays `0x8` for 3 cycles. With the macro, `cycle_count` advances by 3 and `retired_count` by 0.
- Redirects:
  - `branch_taken` with target `0x1FC`: next `address = 0x1FC`, then HALT with `halted = 1`, `address` frozen at `0x1FC`.
  - Target `0x0000_0102`: TRAP, `trap = 1`, `trap_pc = 0x102`, `instr_out = 0x13`.
  - Target `0x200`: TRAP with `trap_pc = 0x200`.
- `instruction = 32'h0010_0073` at PC `0x14`: HALT, `address` held at `0x14`, `instr_valid = 0`. Toggling `branch_taken` in HALT has no effect.
- `rst` pulsed while in TRAP and again mid-stall: next cycle `address = RESET_PC`, state BOOT, `trap = 0`, `halted = 0`, counters 0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, next-PC selection and instruction hand-off for the single-cycle RISC-V core.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_DEPTH = 128,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    input  logic [31:0]          instruction,
    output logic [31:0]          address,
    output logic [31:0]          pc_plus4,
    output logic [31:0]          instr_out,
    output logic                 instr_valid,
    output logic                 halted,
    output logic                 trap,
    output logic [31:0]          trap_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] retired_count,
    output logic [CNT_WIDTH-1:0] cycle_count
`endif
);

    localparam logic [31:0] C_MEM_BYTES = 32'(MEM_DEPTH * 4);
    localparam logic [31:0] C_NOP       = 32'h0000_0013;
    localparam logic [31:0] C_EBREAK    = 32'h0010_0073;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;
    localparam logic [1:0] S_TRAP = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] trap_pc_q, trap_pc_d;
    logic        halted_q, trap_q;
    logic        w_bad_target;
    logic        w_retire;
    logic        w_counting;

    assign pc_plus4 = pc_q + 32'd4;
    assign address  = pc_q;

    // A redirect is illegal if it is misaligned or lies past the last word of memory.
    assign w_bad_target = branch_taken &&
                          ((branch_target[1:0] != 2'b00) || (branch_target >= C_MEM_BYTES));

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        trap_pc_d = trap_pc_q;
        w_retire  = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (stall) begin
                    state_d = S_RUN;
                end else if (instruction == C_EBREAK) begin
                    state_d  = S_HALT;
                    w_retire = 1'b1;
                end else if (w_bad_target) begin
                    state_d   = S_TRAP;
                    trap_pc_d = branch_target;
                end else if (branch_taken) begin
                    pc_d     = branch_target;
                    w_retire = 1'b1;
                end else if (pc_plus4 >= C_MEM_BYTES) begin
                    state_d  = S_HALT;
                    w_retire = 1'b1;
                end else begin
                    pc_d     = pc_plus4;
                    w_retire = 1'b1;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_comb begin
        instr_out   = C_NOP;
        instr_valid = 1'b0;
        if (state_q == S_RUN) begin
            instr_out   = instruction;
            instr_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_PC;
            trap_pc_q <= 32'h0000_0000;
            halted_q  <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            trap_pc_q <= trap_pc_d;
            halted_q  <= (state_d == S_HALT);
            trap_q    <= (state_d == S_TRAP);
        end
    end

    assign halted     = halted_q;
    assign trap       = trap_q;
    assign trap_pc    = trap_pc_q;
    assign w_counting = (state_q == S_BOOT) || (state_q == S_RUN);

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] retired_q, cycle_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
            cycle_q   <= '0;
        end else begin
            if (w_retire) begin
                retired_q <= retired_q + 1'b1;
            end
            if (w_counting) begin
                cycle_q <= cycle_q + 1'b1;
            end
        end
    end

    assign retired_count = retired_q;
    assign cycle_count   = cycle_q;
`else
    logic [CNT_WIDTH-1:0] w_unused_cnt;
    logic                 w_unused_flags;
    assign w_unused_cnt   = '0;
    assign w_unused_flags = w_retire ^ w_counting;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed check of fetch_unit covering boot, stall, redirects, halt and trap.
`default_nettype none

module tb_fetch_unit;

    localparam logic [31:0] N = 32'h0040_0093;
    localparam logic [31:0] E = 32'h0010_0073;
    localparam logic [31:0] P = 32'h0000_0013;
    localparam int          NV = 33;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken;
    logic [31:0] branch_target, instruction;
    logic [31:0] address, pc_plus4, instr_out, trap_pc;
    logic        instr_valid, halted, trap;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retired_count, cycle_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        bt;
        logic [31:0] tgt;
        logic [31:0] instr;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] iout;
        logic        halted;
        logic        trap;
        logic [31:0] tpc;
        logic [31:0] cyc;
        logic [31:0] ret;
    } vec_t;

    vec_t vt[NV];

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instruction   (instruction),
        .address       (address),
        .pc_plus4      (pc_plus4),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .halted        (halted),
        .trap          (trap),
        .trap_pc       (trap_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .retired_count (retired_count),
        .cycle_count   (cycle_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec %0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    task automatic sv(input int i, input logic r, input logic s, input logic b, input logic [31:0] t,
                      input logic [31:0] ins, input logic [31:0] a, input logic v, input logic [31:0] io,
                      input logic h, input logic tr, input logic [31:0] tp,
                      input logic [31:0] c, input logic [31:0] rt);
        vt[i].rst = r;  vt[i].stall = s; vt[i].bt = b;   vt[i].tgt = t;  vt[i].instr = ins;
        vt[i].addr = a; vt[i].valid = v; vt[i].iout = io; vt[i].halted = h;
        vt[i].trap = tr; vt[i].tpc = tp; vt[i].cyc = c;  vt[i].ret = rt;
    endtask

    initial begin
        //     i   rst s  bt tgt           instr addr      v  iout h  t  tpc     cyc ret
        sv( 0, 0, 0, 0, 32'h0,     N, 32'h0,    0, P, 0, 0, 32'h0,   0, 0); // BOOT
        sv( 1, 0, 0, 0, 32'h0,     N, 32'h0,    1, N, 0, 0, 32'h0,   1, 0);
        sv( 2, 0, 0, 0, 32'h0,     N, 32'h4,    1, N, 0, 0, 32'h0,   2, 1);
        sv( 3, 0, 1, 0, 32'h0,     N, 32'h8,    1, N, 0, 0, 32'h0,   3, 2); // stall x3
        sv( 4, 0, 1, 0, 32'h0,     N, 32'h8,    1, N, 0, 0, 32'h0,   4, 2);
        sv( 5, 0, 1, 0, 32'h0,     N, 32'h8,    1, N, 0, 0, 32'h0,   5, 2);
        sv( 6, 0, 0, 1, 32'h1FC,   N, 32'h8,    1, N, 0, 0, 32'h0,   6, 2); // redirect to last word
        sv( 7, 0, 0, 0, 32'h0,     N, 32'h1FC,  1, N, 0, 0, 32'h0,   7, 3); // runs off the end
        sv( 8, 0, 0, 1, 32'h0,     N, 32'h1FC,  0, P, 1, 0, 32'h0,   8, 4);
        sv( 9, 0, 0, 0, 32'h0,     N, 32'h1FC,  0, P, 1, 0, 32'h0,   8, 4);
        sv(10, 1, 0, 0, 32'h0,     N, 32'h1FC,  0, P, 1, 0, 32'h0,   8, 4); // reset from HALT
        sv(11, 0, 0, 0, 32'h0,     N, 32'h0,    0, P, 0, 0, 32'h0,   0, 0);
        sv(12, 0, 0, 1, 32'h102,   N, 32'h0,    1, N, 0, 0, 32'h0,   1, 0); // misaligned target
        sv(13, 0, 0, 1, 32'h40,    N, 32'h0,    0, P, 0, 1, 32'h102, 2, 0);
        sv(14, 1, 0, 0, 32'h0,     N, 32'h0,    0, P, 0, 1, 32'h102, 2, 0); // reset from TRAP
        sv(15, 0, 0, 0, 32'h0,     N, 32'h0,    0, P, 0, 0, 32'h0,   0, 0);
        sv(16, 0, 0, 1, 32'h14,    N, 32'h0,    1, N, 0, 0, 32'h0,   1, 0);
        sv(17, 0, 0, 0, 32'h0,     E, 32'h14,   1, E, 0, 0, 32'h0,   2, 1); // EBREAK
        sv(18, 0, 0, 1, 32'h20,    N, 32'h14,   0, P, 1, 0, 32'h0,   3, 2);
        sv(19, 0, 0, 0, 32'h0,     N, 32'h14,   0, P, 1, 0, 32'h0,   3, 2);
        sv(20, 1, 0, 0, 32'h0,     N, 32'h14,   0, P, 1, 0, 32'h0,   3, 2);
        sv(21, 0, 0, 0, 32'h0,     N, 32'h0,    0, P, 0, 0, 32'h0,   0, 0);
        sv(22, 0, 0, 1, 32'h200,   N, 32'h0,    1, N, 0, 0, 32'h0,   1, 0); // out-of-range target
        sv(23, 0, 0, 0, 32'h0,     N, 32'h0,    0, P, 0, 1, 32'h200, 2, 0);
        sv(24, 1, 0, 0, 32'h0,     N, 32'h0,    0, P, 0, 1, 32'h200, 2, 0);
        sv(25, 0, 0, 0, 32'h0,     N, 32'h0,    0, P, 0, 0, 32'h0,   0, 0);
        sv(26, 0, 1, 0, 32'h0,     N, 32'h0,    1, N, 0, 0, 32'h0,   1, 0);
        sv(27, 1, 1, 0, 32'h0,     N, 32'h0,    1, N, 0, 0, 32'h0,   2, 0); // reset mid-stall
        sv(28, 0, 0, 0, 32'h0,     N, 32'h0,    0, P, 0, 0, 32'h0,   0, 0);
        sv(29, 0, 0, 0, 32'h0,     N, 32'h0,    1, N, 0, 0, 32'h0,   1, 0);
        sv(30, 0, 1, 1, 32'h3,     E, 32'h4,    1, E, 0, 0, 32'h0,   2, 1); // stall beats EBREAK/trap
        sv(31, 0, 0, 0, 32'h0,     E, 32'h4,    1, E, 0, 0, 32'h0,   3, 1);
        sv(32, 0, 0, 0, 32'h0,     N, 32'h4,    0, P, 1, 0, 32'h0,   4, 2);

        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; instruction = N;
        @(posedge clk); #1;
        chk(-1, "rst_address", address, 32'h0);
        chk(-1, "rst_valid",   {31'h0, instr_valid}, 32'h0);
        chk(-1, "rst_iout",    instr_out, P);
        chk(-1, "rst_halted",  {31'h0, halted}, 32'h0);
        chk(-1, "rst_trap",    {31'h0, trap}, 32'h0);
        chk(-1, "rst_trap_pc", trap_pc, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            rst = vt[i].rst; stall = vt[i].stall; branch_taken = vt[i].bt;
            branch_target = vt[i].tgt; instruction = vt[i].instr;
            #1;
            chk(i, "address",     address, vt[i].addr);
            chk(i, "pc_plus4",    pc_plus4, vt[i].addr + 32'd4);
            chk(i, "instr_valid", {31'h0, instr_valid}, {31'h0, vt[i].valid});
            chk(i, "instr_out",   instr_out, vt[i].iout);
            chk(i, "halted",      {31'h0, halted}, {31'h0, vt[i].halted});
            chk(i, "trap",        {31'h0, trap}, {31'h0, vt[i].trap});
            chk(i, "trap_pc",     trap_pc, vt[i].tpc);
`ifdef FETCH_PERF_CNT_EN
            chk(i, "cycle_count",   cycle_count, vt[i].cyc);
            chk(i, "retired_count", retired_count, vt[i].ret);
`endif
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
